// File: rtl/router_pkg.sv
// Shared definitions for the 5-port mesh router: direction encodings, port count,
// flit-type bit offsets and the arbiter slot-to-port mapping.
package router_pkg;

  localparam int NUM_PORTS    = 5;
  localparam int NUM_SLOTS    = NUM_PORTS - 1;
  // Flit-type bits are counted down from the item MSB: head at DATA_W-1, tail at DATA_W-2
  localparam int HEAD_BIT_OFS = 1;
  localparam int TAIL_BIT_OFS = 2;

  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_E = 3'd1,
    DIR_S = 3'd2,
    DIR_W = 3'd3,
    DIR_L = 3'd4
  } dir_e;

  // Each output arbitrates over the four other inputs; slot i skips output q itself
  function automatic int slot_to_port(input int q, input int slot);
    return (slot < q) ? slot : slot + 1;
  endfunction

endpackage

// File: rtl/router_xbar_pipe_if.sv
// Rx-buffer / tx-channel bundle of the router crossbar; master is the router side.
interface router_xbar_pipe_if
  import router_pkg::*;
#(
  parameter int DATA_W = 40
);
  logic [NUM_PORTS*DATA_W-1:0] in_item;
  logic [NUM_PORTS-1:0]        in_empty;
  logic [NUM_PORTS-1:0]        in_read;
  logic [NUM_PORTS*DATA_W-1:0] out_item;
  logic [NUM_PORTS-1:0]        out_ena;
  logic [NUM_PORTS-1:0]        out_busy;
  logic                        err;

  modport master (
    input  in_item, in_empty, out_busy,
    output in_read, out_item, out_ena, err
  );

  modport slave (
    output in_item, in_empty, out_busy,
    input  in_read, out_item, out_ena, err
  );
endinterface

// File: rtl/rr_arbiter_n.sv
// N-request round-robin arbiter: one-hot combinational grant, registered search pointer
// that moves to one past the winner only when a grant is issued.
module rr_arbiter_n #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] gnt_idx_s;
  logic             found_s;

  // First requester at or after the pointer, wrapping
  always_comb begin
    int  idx;
    logic hit;
    idx       = 0;
    hit       = 1'b0;
    gnt       = '0;
    gnt_idx_s = '0;
    found_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx       = (int'(ptr_r) + k) % N;
      hit       = !found_s && req[idx];
      gnt[idx]  = hit;
      gnt_idx_s = hit ? PTR_W'(idx) : gnt_idx_s;
      found_s   = found_s | hit;
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= (gnt_idx_s == PTR_W'(N - 1)) ? '0 : gnt_idx_s + 1'b1;
    end
  end

endmodule

// File: rtl/router_xbar_pipe.sv
// 5-port XY-routed crossbar with per-output round-robin arbitration and a registered
// output stage. Define ROUTER_WORMHOLE_EN to add head/tail flit locking of outputs.
module router_xbar_pipe
  import router_pkg::*;
#(
  parameter int ID     = 0,
  parameter int MESH_X = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 40
) (
  input logic               clk,
  input logic               reset,
  router_xbar_pipe_if.master bus
);

  localparam int                HALF_W = ADDR_W / 2;
  localparam logic [HALF_W-1:0] MY_X   = HALF_W'(ID % MESH_X);
  localparam logic [HALF_W-1:0] MY_Y   = HALF_W'(ID / MESH_X);

  function automatic dir_e xy_route(input logic [ADDR_W-1:0] addr);
    logic [HALF_W-1:0] dx;
    logic [HALF_W-1:0] dy;
    dx = addr[HALF_W-1:0];
    dy = addr[ADDR_W-1:HALF_W];
    if (dx > MY_X)      return DIR_E;
    else if (dx < MY_X) return DIR_W;
    else if (dy > MY_Y) return DIR_N;
    else if (dy < MY_Y) return DIR_S;
    else                return DIR_L;
  endfunction

  logic [DATA_W-1:0]     item_s     [NUM_PORTS];
  dir_e                  route_s    [NUM_PORTS];
  logic [NUM_PORTS-1:0]  req_s      [NUM_PORTS];
  logic [NUM_SLOTS-1:0]  slot_req_s [NUM_PORTS];
  logic [NUM_SLOTS-1:0]  slot_gnt_s [NUM_PORTS];
  logic [NUM_PORTS-1:0]  gnt_s      [NUM_PORTS];
  logic [DATA_W-1:0]     sel_item_s [NUM_PORTS];
  logic [DATA_W-1:0]     out_item_r [NUM_PORTS];
  logic [NUM_PORTS*DATA_W-1:0] out_item_s;
  logic [NUM_PORTS-1:0]  rd_s;
  logic [NUM_PORTS-1:0]  out_ena_r;
  logic                  self_route_s;
  logic                  err_r;

`ifdef ROUTER_WORMHOLE_EN
  logic [NUM_PORTS-1:0]  head_s;
  logic [NUM_PORTS-1:0]  tail_s;
  dir_e                  lock_route_r [NUM_PORTS];
  logic [NUM_PORTS-1:0]  out_locked_r;
  logic [2:0]            out_owner_r  [NUM_PORTS];
`endif

  // Head-item routing and detection of items that would turn back on themselves
  always_comb begin
    self_route_s = 1'b0;
`ifdef ROUTER_WORMHOLE_EN
    head_s = '0;
    tail_s = '0;
`endif
    for (int p = 0; p < NUM_PORTS; p++) begin
      item_s[p] = bus.in_item[p*DATA_W +: DATA_W];
`ifdef ROUTER_WORMHOLE_EN
      head_s[p]  = item_s[p][DATA_W-HEAD_BIT_OFS];
      tail_s[p]  = item_s[p][DATA_W-TAIL_BIT_OFS];
      // Body and tail flits follow the path their head opened
      route_s[p] = head_s[p] ? xy_route(item_s[p][ADDR_W-1:0]) : lock_route_r[p];
`else
      route_s[p] = xy_route(item_s[p][ADDR_W-1:0]);
`endif
      self_route_s = self_route_s | (!bus.in_empty[p] && (int'(route_s[p]) == p));
    end
  end

  // Per-output request vectors, compacted into the four arbiter slots
  always_comb begin
    logic lock_ok;
    lock_ok = 1'b1;
    for (int q = 0; q < NUM_PORTS; q++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
`ifdef ROUTER_WORMHOLE_EN
        lock_ok = !out_locked_r[q] || (int'(out_owner_r[q]) == p);
`else
        lock_ok = 1'b1;
`endif
        req_s[q][p] = !bus.in_empty[p] && (int'(route_s[p]) == q) && (p != q)
                      && !bus.out_busy[q] && lock_ok;
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_req_s[q][i] = req_s[q][slot_to_port(q, i)];
      end
    end
  end

  for (genvar q = 0; q < NUM_PORTS; q++) begin : g_arb
    rr_arbiter_n #(.N(NUM_SLOTS)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (slot_req_s[q]),
      .gnt   (slot_gnt_s[q])
    );
  end

  // Expand slot grants back to input ports and select the winning item per output
  always_comb begin
    int p;
    p    = 0;
    rd_s = '0;
    for (int q = 0; q < NUM_PORTS; q++) begin
      gnt_s[q]      = '0;
      sel_item_s[q] = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        p             = slot_to_port(q, i);
        gnt_s[q][p]   = slot_gnt_s[q][i];
        sel_item_s[q] = sel_item_s[q] | (slot_gnt_s[q][i] ? item_s[p] : {DATA_W{1'b0}});
      end
      rd_s = rd_s | gnt_s[q];
    end
  end

  // Output stage: latch the granted item, hold it while idle; err is sticky
  always_ff @(posedge clk) begin
    if (reset) begin
      out_ena_r <= '0;
      err_r     <= 1'b0;
      for (int q = 0; q < NUM_PORTS; q++) begin
        out_item_r[q] <= '0;
      end
    end else begin
      err_r <= err_r | self_route_s;
      for (int q = 0; q < NUM_PORTS; q++) begin
        out_ena_r[q] <= |gnt_s[q];
        if (|gnt_s[q]) begin
          out_item_r[q] <= sel_item_s[q];
        end
      end
    end
  end

`ifdef ROUTER_WORMHOLE_EN
  // Output ownership: a granted head locks, a granted tail releases (both -> stays free)
  always_ff @(posedge clk) begin
    if (reset) begin
      out_locked_r <= '0;
      for (int q = 0; q < NUM_PORTS; q++) begin
        out_owner_r[q]  <= 3'd0;
        lock_route_r[q] <= DIR_N;
      end
    end else begin
      for (int q = 0; q < NUM_PORTS; q++) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (gnt_s[q][p] && tail_s[p]) begin
            out_locked_r[q] <= 1'b0;
          end else if (gnt_s[q][p] && head_s[p]) begin
            out_locked_r[q] <= 1'b1;
            out_owner_r[q]  <= 3'(p);
          end
        end
        if (rd_s[q] && head_s[q]) begin
          lock_route_r[q] <= route_s[q];
        end
      end
    end
  end
`endif

  // Flatten registered outputs onto the bus
  always_comb begin
    out_item_s = '0;
    for (int q = 0; q < NUM_PORTS; q++) begin
      out_item_s[q*DATA_W +: DATA_W] = out_item_r[q];
    end
  end

  assign bus.in_read  = reset ? {NUM_PORTS{1'b0}} : rd_s;
  assign bus.out_item = out_item_s;
  assign bus.out_ena  = out_ena_r;
  assign bus.err      = err_r;

endmodule
